// File: rtl/montgomery_pkg.sv
// Shared definitions for the Montgomery blocks: FSM encoding, counter width
// and the modulus legality check used by r_red generation and mul/conv.
package montgomery_pkg;

    localparam int MAX_NBITS = 2048;
    localparam int MSZ_W_DFLT = 11;
    localparam int CNT_W = MSZ_W_DFLT + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_e;

    // Legal means odd, exactly m_size bits long, and m_size fits the datapath.
    // Shifting down by m_size-1 must leave exactly 1: the top bit is set and
    // nothing above it is. m_size=0 wraps the shift amount and yields 0.
    function automatic logic m_is_legal(input logic [MAX_NBITS-1:0] m,
                                        input int unsigned          m_size,
                                        input int unsigned          nbits);
        logic [MAX_NBITS-1:0] top;
        top = m >> (m_size - 1);
        return m[0] && (m_size != 0) && (m_size <= nbits) &&
               (top == MAX_NBITS'(1));
    endfunction

endpackage

// File: rtl/montgomery_r_red_gen_mod_dbl_reduce.sv
// One reduction step: y = 2x mod m, valid while x < m (so one subtract suffices).
module mod_dbl_reduce #(
    parameter int NBITS = 2048
) (
    input  logic [NBITS-1:0] x_i,
    input  logic [NBITS-1:0] m_i,
    output logic [NBITS-1:0] y_o
);

    logic [NBITS:0] t;
    logic [NBITS:0] m_ext;

    assign t     = {x_i, 1'b0};
    assign m_ext = {1'b0, m_i};
    assign y_o   = (t >= m_ext) ? NBITS'(t - m_ext) : t[NBITS-1:0];

endmodule

// File: rtl/montgomery_r_red_gen.sv
// Iterative generator of r_red = 2^(2*m_size) mod m: starts from 1 and doubles
// modulo m once per clock for 2*m_size cycles.
module montgomery_r_red_gen #(
    parameter int NBITS = 2048,
    parameter int MSZ_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_p,
    input  logic [NBITS-1:0] m,
    input  logic [MSZ_W-1:0] m_size,
    output logic [NBITS-1:0] r_red,
    output logic             done_irq_p,
    output logic             busy,
    output logic             err
);

    import montgomery_pkg::*;

    localparam logic [MSZ_W:0] CNT_ONE = 1;

    state_e           state_q, state_d;
    logic [NBITS-1:0] m_q, m_d;
    logic [NBITS-1:0] x_q, x_d;
    logic [MSZ_W:0]   cnt_q, cnt_d;
    logic [NBITS-1:0] r_red_q, r_red_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic [NBITS-1:0] dbl_x;
    logic             legal;

    // NBITS must not exceed MAX_NBITS; the cast zero-extends m for the shared check.
    assign legal = m_is_legal(MAX_NBITS'(m), 32'(m_size), NBITS);

    mod_dbl_reduce #(.NBITS(NBITS)) u_dbl (
        .x_i (x_q),
        .m_i (m_q),
        .y_o (dbl_x)
    );

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        r_red_d = r_red_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (enable_p) begin
                    if (legal) begin
                        m_d     = m;
                        // m=1 gives R mod 1 = 0; starting at 1 would break x < m.
                        x_d     = (m == NBITS'(1)) ? '0 : NBITS'(1);
                        cnt_d   = {m_size, 1'b0};
                        err_d   = 1'b0;
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end else begin
                        err_d   = 1'b1;
                        r_red_d = '0;
                        done_d  = 1'b1;
                        state_d = ERR;
                    end
                end
            end
            RUN: begin
                x_d   = dbl_x;
                cnt_d = cnt_q - 1'b1;
                // Result, pulse and busy drop are registered on the final step
                // so they are all visible in the DONE cycle itself.
                if (cnt_q == CNT_ONE) begin
                    r_red_d = dbl_x;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of its neighbours.
    // NOTE: the datapath registers are reset too, so an aborted run leaves no
    // stale modulus or partial result behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            m_q     <= '0;
            x_q     <= '0;
            cnt_q   <= '0;
            r_red_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            r_red_q <= r_red_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign r_red      = r_red_q;
    assign done_irq_p = done_q;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule
